// File: rtl/pwm_gen.sv
// NCH-channel PWM generator. Duty bytes are double-buffered into a shadow
// register that only reloads at period wrap (or continuously while idle).
module pwm_gen #(
    parameter int NCH      = 4,
    parameter int PRESCALE = 4,
    parameter int PERIOD   = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [31:0]        pwm_cfg,
    output logic [NCH-1:0]     pwm_out,
    output logic               period_start,
    output logic [8*NCH-1:0]   duty_active
);

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);
    localparam logic [7:0]  PER_LAST = 8'(PERIOD - 1);

    logic [15:0]      pre_q,    pre_d;
    logic [7:0]       per_q,    per_d;
    logic [8*NCH-1:0] shadow_q, shadow_d;
    logic [NCH-1:0]   pwm_q,    pwm_d;
    logic             start_q,  start_d;
    logic             en_q;
    logic             tick;
    logic             wrap;

    always_comb begin
        tick = (pre_q == PRE_LAST);
        wrap = tick && (per_q == PER_LAST);

        // NOTE: every signal driven here gets a default first, so no latch is inferred.
        pre_d    = '0;
        per_d    = '0;
        shadow_d = pwm_cfg[8*NCH-1:0];
        pwm_d    = '0;
        start_d  = 1'b0;

        if (en) begin
            pre_d = tick ? 16'd0 : pre_q + 16'd1;
            if (wrap) begin
                per_d = 8'd0;
            end else if (tick) begin
                per_d = per_q + 8'd1;
            end else begin
                per_d = per_q;
            end
            shadow_d = wrap ? pwm_cfg[8*NCH-1:0] : shadow_q;
            for (int i = 0; i < NCH; i++) begin
                pwm_d[i] = (per_q < shadow_q[8*i +: 8]);
            end
            // A fresh enable restarts the counters at zero, which is a period start too.
            start_d = wrap || !en_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q    <= '0;
            per_q    <= '0;
            shadow_q <= '0;
            pwm_q    <= '0;
            start_q  <= 1'b0;
            en_q     <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            per_q    <= per_d;
            shadow_q <= shadow_d;
            pwm_q    <= pwm_d;
            start_q  <= start_d;
            en_q     <= en;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = start_q;
    assign duty_active  = shadow_q;

    if (8*NCH < 32) begin : g_unused_cfg
        logic unused_cfg;
        assign unused_cfg = ^pwm_cfg[31:8*NCH];
    end

endmodule

// File: tb/tb_pwm_gen.sv
// Bench for pwm_gen: two instances (PRESCALE 1 and 4) against a time-based
// behavioural model, plus hand-computed per-period expectations.
module tb_pwm_gen;

    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] pwm_cfg;

    logic [3:0]  pwm1, pwm4;
    logic        ps1, ps4;
    logic [31:0] duty1, duty4;

    always #5 clk = ~clk;

    pwm_gen #(.NCH(NCH), .PRESCALE(1), .PERIOD(255)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .pwm_cfg(pwm_cfg),
        .pwm_out(pwm1), .period_start(ps1), .duty_active(duty1)
    );

    pwm_gen #(.NCH(NCH), .PRESCALE(4), .PERIOD(255)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .pwm_cfg(pwm_cfg),
        .pwm_out(pwm4), .period_start(ps4), .duty_active(duty4)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: position within the enabled run, counted in clocks since enable.
    int          run_k    [2];
    logic [31:0] m_shadow [2];
    logic [3:0]  m_pwm    [2];
    logic        m_ps     [2];
    logic        m_en_prev;
    int          m_len;
    int          m_tick;

    function automatic int pres(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                run_k[d]    = 0;
                m_shadow[d] = '0;
                m_pwm[d]    = '0;
                m_ps[d]     = 1'b0;
            end
            m_en_prev = 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                m_len = pres(d) * 255;
                if (en) begin
                    m_tick = run_k[d] / pres(d);
                    for (int i = 0; i < NCH; i++)
                        m_pwm[d][i] = (m_tick < int'(m_shadow[d][8*i +: 8]));
                    m_ps[d] = (run_k[d] == m_len - 1) || !m_en_prev;
                    if (run_k[d] == m_len - 1) begin
                        m_shadow[d] = pwm_cfg;
                        run_k[d]    = 0;
                    end else begin
                        run_k[d]    = run_k[d] + 1;
                    end
                end else begin
                    m_pwm[d]    = '0;
                    m_ps[d]     = 1'b0;
                    m_shadow[d] = pwm_cfg;
                    run_k[d]    = 0;
                end
            end
            m_en_prev = en;
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            check("pwm_out_p1",      {28'd0, pwm1}, {28'd0, m_pwm[0]});
            check("period_start_p1", {31'd0, ps1},  {31'd0, m_ps[0]});
            check("duty_active_p1",  duty1,         m_shadow[0]);
            check("pwm_out_p4",      {28'd0, pwm4}, {28'd0, m_pwm[1]});
            check("period_start_p4", {31'd0, ps4},  {31'd0, m_ps[1]});
            check("duty_active_p4",  duty4,         m_shadow[1]);
        end
    end

    // Per-cycle capture for the hand-computed period checks.
    logic [3:0]  pwm_log  [1020];
    logic        ps_log   [1020];
    logic [31:0] duty_log [1020];

    task automatic sample(input int d, input int n, input int chg_idx,
                          input logic [31:0] chg_cfg, input logic chg_en);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            pwm_log[c]  = (d == 0) ? pwm1  : pwm4;
            ps_log[c]   = (d == 0) ? ps1   : ps4;
            duty_log[c] = (d == 0) ? duty1 : duty4;
            if (c == chg_idx) begin
                pwm_cfg = chg_cfg;
                en      = chg_en;
            end
        end
    endtask

    task automatic wait_ps(input int d, input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!((d == 0) ? ps1 : ps4) && k < budget);
        check("wait_period_start", {31'd0, ((d == 0) ? ps1 : ps4)}, 32'd1);
    endtask

    function automatic int highs(input int ch, input int lo, input int hi);
        int s;
        s = 0;
        for (int c = lo; c < hi; c++) s += int'(pwm_log[c][ch]);
        return s;
    endfunction

    function automatic int ps_count(input int lo, input int hi);
        int s;
        s = 0;
        for (int c = lo; c < hi; c++) s += int'(ps_log[c]);
        return s;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst     = 1'b0;
        en      = 1'b0;
        pwm_cfg = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pwm1",  {28'd0, pwm1}, 32'd0);
        check("rst_ps1",   {31'd0, ps1},  32'd0);
        check("rst_duty1", duty1,         32'd0);
        check("rst_pwm4",  {28'd0, pwm4}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Test 1: prescale 1, mixed duties, idle load then enable.
        pwm_cfg = 32'h0000_80FF;
        repeat (3) @(negedge clk);
        check("t1_idle_load", duty1, 32'h0000_80FF);
        en = 1'b1;
        sample(0, 510, -1, '0, 1'b1);
        check("t1_ps_rise",  {31'd0, ps_log[0]},   32'd1);
        check("t1_ch0_hi",   highs(0, 0, 255),     32'd255);
        check("t1_ch1_hi",   highs(1, 0, 255),     32'd128);
        check("t1_ch1_edge", {30'd0, pwm_log[127][1], pwm_log[128][1]}, 32'd2);
        check("t1_ch23_hi",  highs(2, 0, 510) + highs(3, 0, 510), 32'd0);
        check("t1_ps_cnt",   ps_count(0, 510),     32'd3);
        check("t1_ps_wrap",  {31'd0, ps_log[254]}, 32'd1);
        check("t1_ps_next",  {31'd0, ps_log[509]}, 32'd1);
        check("t1_ch1_p2",   highs(1, 255, 510),   32'd128);

        // Test 2: prescale 4, duty 1 -> 4 clks high per 1020.
        pwm_cfg = 32'h0000_0001;
        wait_ps(1, 1100);
        sample(1, 1020, -1, '0, 1'b1);
        check("t2_ch0_hi",    highs(0, 0, 1020),     32'd4);
        check("t2_first_hi",  {31'd0, pwm_log[0][0]}, 32'd1);
        check("t2_after_hi",  {31'd0, pwm_log[4][0]}, 32'd0);
        check("t2_ps_cnt",    ps_count(0, 1020),     32'd1);
        check("t2_ps_wrap",   {31'd0, ps_log[1019]}, 32'd1);

        // Test 3: mid-period cfg change only takes effect at the wrap.
        pwm_cfg = 32'h0000_0040;
        wait_ps(0, 300);
        sample(0, 255, 49, 32'h0000_00C0, 1'b1);
        check("t3_cur_hi",     highs(0, 0, 255), 32'd64);
        check("t3_duty_hold",  duty_log[253],    32'h40);
        check("t3_duty_wrap",  duty_log[254],    32'hC0);
        sample(0, 255, -1, '0, 1'b1);
        check("t3_next_hi",    highs(0, 0, 255), 32'd192);

        // Test 4: disable mid-period, reconfigure while idle, re-enable.
        pwm_cfg = 32'h0000_00FF;
        wait_ps(0, 300);
        sample(0, 101, 100, 32'h0000_00FF, 1'b0);
        check("t4_hi_before", highs(0, 0, 101), 32'd101);
        @(negedge clk);
        check("t4_off_next",  {28'd0, pwm1}, 32'd0);
        pwm_cfg = 32'h0000_0010;
        repeat (3) @(negedge clk);
        check("t4_idle_duty", duty1, 32'h10);
        en = 1'b1;
        sample(0, 255, -1, '0, 1'b1);
        check("t4_ps_rise",   {31'd0, ps_log[0]}, 32'd1);
        check("t4_first_hi",  highs(0, 0, 255),   32'd16);
        check("t4_ps_quiet",  ps_count(1, 254),   32'd0);

        // Test 5: asynchronous reset mid-period, then restart.
        pwm_cfg = 32'h0000_00FF;
        wait_ps(0, 300);
        sample(0, 20, -1, '0, 1'b1);
        check("t5_pre_hi",   {31'd0, pwm1[0]}, 32'd1);
        check("t5_pre_duty", duty1,            32'hFF);
        #1 rst = 1'b0;
        #1;
        check("t5_rst_pwm",  {28'd0, pwm1}, 32'd0);
        check("t5_rst_ps",   {31'd0, ps1},  32'd0);
        check("t5_rst_duty", duty1,         32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sample(0, 256, -1, '0, 1'b1);
        check("t5_ps_start", {31'd0, ps_log[0]},     32'd1);
        check("t5_ps_quiet", ps_count(1, 254),       32'd0);
        check("t5_ps_wrap",  {31'd0, ps_log[254]},   32'd1);
        check("t5_hi_first", highs(0, 0, 255),       32'd0);
        check("t5_hi_next",  {31'd0, pwm_log[255][0]}, 32'd1);
        check("t5_duty",     duty_log[254],          32'hFF);

        // Test 6: cfg change in the exact wrap cycle is the value loaded.
        pwm_cfg = 32'h0000_0020;
        wait_ps(0, 300);
        sample(0, 255, 253, 32'h0000_0030, 1'b1);
        check("t6_cur_hi",  highs(0, 0, 255), 32'd32);
        sample(0, 255, -1, '0, 1'b1);
        check("t6_next_hi", highs(0, 0, 255), 32'd48);
        check("t6_duty",    duty_log[0],      32'h30);

        // Randomised traffic, checked cycle by cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) pwm_cfg = $urandom;
            if ($urandom_range(0, 399) == 0) en = ~en;
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
